fetch_unit: RTL and testbench

Instruction fetch stage for the prz RISC-V core. It owns the program counter, issues one outstanding word request at a time to instruction memory, and holds the fetched instruction for decode until it is consumed. It drives the select and sequential-address inputs of the 32-bit next-PC `mux2_1` instance (N=32) and takes that mux's output back as `next_pc`. The branch target goes to the mux's second data input directly from execute.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word request outstanding at a time,
// and holds the fetched instruction until decode consumes it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] next_pc,
  output logic        pc_sel,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        load_pc;
  logic        unused_low_bits;

  // A redirect always moves the pc; otherwise it only advances when decode takes the instruction.
  assign load_pc         = branch_taken | ((state == VALID) & ~stall);
  assign pc_sel          = branch_taken;
  assign pc_plus4        = pc + 32'd4;
  assign imem_addr       = pc;
  assign instr_pc        = pc;
  assign unused_low_bits = ^next_pc[1:0];

  // PC, fetch state machine and registered fetch/decode handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP;
    end else begin
      if (load_pc) begin
        pc <= {next_pc[31:2], 2'b00};
      end
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          // A branch before grant just retargets the pending request via the pc.
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= branch_taken ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (branch_taken) begin
              imem_req <= 1'b1;
              state    <= REQ;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end else if (branch_taken) begin
            state <= DROP;
          end
        end
        DROP: begin
          // The stale response must drain before the redirected request can go out.
          if (imem_rvalid) begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end
        VALID: begin
          if (branch_taken || !stall) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios, then randomized
// traffic against a transaction-level model of the fetch protocol.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] next_pc;
  logic        pc_sel;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model: pc, held instruction, and whether a request is pending/outstanding/stale
  logic [31:0] m_pc    = RPC;
  logic [31:0] m_instr = NOP;
  bit m_valid = 1'b0, m_req = 1'b0, m_out = 1'b0, m_stale = 1'b0, m_idle = 1'b1;

  // memory responder state for the random phase
  bit mem_pend = 1'b0;
  int mem_wait = 0;

  always #5 clk = ~clk;

  // the next-PC mux sitting outside the fetch unit
  assign next_pc = pc_sel ? target : pc_plus4;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .next_pc(next_pc),
    .pc_sel(pc_sel), .pc_plus4(pc_plus4), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Apply one clock of inputs, then advance the model with those same inputs.
  task automatic step(input logic r, input logic b, input logic [31:0] t, input logic s,
                      input logic g, input logic v, input logic [31:0] d);
    logic [31:0] nxt;
    @(negedge clk);
    rst = r; branch_taken = b; target = t; stall = s;
    imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    @(posedge clk);
    if (r) begin
      m_pc = RPC; m_instr = NOP; m_valid = 0; m_req = 0; m_out = 0; m_stale = 0; m_idle = 1;
    end else begin
      nxt = b ? t : m_pc + 32'd4;
      if (b || (m_valid && !s)) m_pc = {nxt[31:2], 2'b00};
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        if (g) begin m_req = 0; m_out = 1; m_stale = b; end
      end else if (m_out) begin
        if (v) begin
          m_out = 0;
          if (m_stale || b) m_req = 1;
          else begin m_valid = 1; m_instr = d; end
        end else if (b) m_stale = 1;
      end else if (m_valid) begin
        if (b || !s) begin m_valid = 0; m_req = 1; end
      end
    end
    #1;
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("pc_sel", {31'd0, pc_sel}, {31'd0, branch_taken});
    end
  end

  logic [31:0] xa, xb, xc, rtgt, rdat;
  logic        rb, rs, rg, rv, rr;

  initial begin
    xa = 32'h0010_0113; xb = 32'h0020_0193; xc = 32'h0030_0213;
    // reset and first fetch
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk_en = 1'b1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_plus4", pc_plus4, 32'h0000_0104);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_ipc", instr_pc, 32'h0000_0100);
    // sequential stream
    step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_addr1", imem_addr, 32'h0000_0104);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, xa);
    chk("seq_instr_a", instr, xa);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_addr2", imem_addr, 32'h0000_0108);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, xb);
    chk("seq_instr_b", instr, xb);
    // stall hold
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      chk("stall_instr", instr, xb);
      chk("stall_ipc", instr_pc, 32'h0000_0108);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("after_stall_addr", imem_addr, 32'h0000_010C);
    step(0, 0, 0, 0, 1, 0, 0);
    // branch during WAIT, stale data arrives two cycles later
    step(0, 1, 32'h0000_2002, 0, 0, 0, 0);
    chk("drop_ipc", instr_pc, 32'h0000_2000);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_2000);
    chk("drop_instr", instr, xb);
    // branch coincident with rvalid, then gnt withheld three cycles
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h0000_0040, 0, 0, 1, 32'h1111_1111);
    chk("coin_valid", {31'd0, instr_valid}, 32'd0);
    chk("coin_instr", instr, xb);
    for (int i = 0; i < 4; i++) begin
      chk("gnt_wait_addr", imem_addr, 32'h0000_0040);
      chk("gnt_wait_req", {31'd0, imem_req}, 32'd1);
      step(0, 0, 0, 0, (i == 3) ? 1'b1 : 1'b0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1, xc);
    chk("coin_ipc", instr_pc, 32'h0000_0040);
    // wrap, then mid-operation reset
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0033);
    chk("wrap_plus4", pc_plus4, 32'h0000_0000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0000_0100);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("restart_addr", imem_addr, 32'h0000_0100);
    chk("restart_req", {31'd0, imem_req}, 32'd1);

    // randomized traffic; memory response comes 1..3 cycles after grant
    step(1, 0, 0, 0, 0, 0, 0);
    mem_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rr   = ($urandom_range(0, 199) == 0);
      rb   = ($urandom_range(0, 9) == 0);
      rs   = $urandom_range(0, 1) == 1;
      rtgt = $urandom;
      rdat = $urandom;
      rg   = m_req && ($urandom_range(0, 3) != 0);
      rv   = 1'b0;
      if (mem_pend) begin
        if (mem_wait == 0) rv = 1'b1;
        else mem_wait--;
      end
      step(rr, rb, rtgt, rs, rg, rv, rdat);
      if (rr || rv) mem_pend = 1'b0;
      if (!rr && rg && !mem_pend && !m_req) begin
        mem_pend = 1'b1;
        mem_wait = $urandom_range(0, 2);
      end
    end
    step(0, 0, 0, 1, 0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
